// File: rtl/eb_rr_arbiter.sv
// rtl/eb_rr_arbiter.sv - N-to-1 round-robin req/ack arbiter with registered output stage
// Define EB_ARB_LOCK_EN to hold the grant on one requester until its t_last beat.
module eb_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     t_req,
    output logic [N-1:0]     t_ack,
    input  logic [N*W-1:0]   t_data,
    input  logic [N-1:0]     t_last,
    output logic             i_req,
    input  logic             i_ack,
    output logic [W-1:0]     i_data,
    output logic [IDW-1:0]   i_id
);

    logic           req_q;
    logic [W-1:0]   data_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] prio_q;
    logic [IDW-1:0] prio_d;

    logic [N-1:0]   g;
    logic [IDW-1:0] gidx;
    logic [W-1:0]   gdata;
    logic           found;
    int             k;
    logic           load;
    logic           xfer;

`ifdef EB_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} lock_e;
    lock_e          lock_q;
    logic [IDW-1:0] lk_q;
`else
    logic unused_last;
    assign unused_last = ^t_last;
`endif

    // Rotating search: first requester at or above prio, wrapping modulo N.
    always_comb begin
        g     = '0;
        gidx  = '0;
        found = 1'b0;
        k     = 0;
`ifdef EB_ARB_LOCK_EN
        if (lock_q == LOCKED) begin
            if (t_req[lk_q]) begin
                g[lk_q] = 1'b1;
                gidx    = lk_q;
            end
        end else
`endif
        begin
            for (int i = 0; i < N; i++) begin
                k = int'(prio_q) + i;
                if (k >= N) k = k - N;
                if (!found && t_req[k]) begin
                    found = 1'b1;
                    g[k]  = 1'b1;
                    gidx  = IDW'(k);
                end
            end
        end
    end

    always_comb begin
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) gdata = t_data[i*W +: W];
        end
    end

    assign prio_d = (gidx == IDW'(N-1)) ? '0 : gidx + 1'b1;

    // Slot may refill in the same cycle it drains; ack is masked while in reset.
    assign load  = !req_q || i_ack;
    assign t_ack = (load && reset_n) ? g : '0;
    assign xfer  = |t_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            prio_q <= '0;
`ifdef EB_ARB_LOCK_EN
            lock_q <= UNLOCKED;
            lk_q   <= '0;
`endif
        end else begin
            if (xfer) begin
                req_q  <= 1'b1;
                data_q <= gdata;
                id_q   <= gidx;
                prio_q <= prio_d;
            end else if (i_ack) begin
                req_q  <= 1'b0;
            end
`ifdef EB_ARB_LOCK_EN
            if (xfer) begin
                case (lock_q)
                    UNLOCKED: if (!t_last[gidx]) begin
                        lock_q <= LOCKED;
                        lk_q   <= gidx;
                    end
                    LOCKED: if (t_last[gidx]) lock_q <= UNLOCKED;
                    default: lock_q <= UNLOCKED;
                endcase
            end
`endif
        end
    end

    assign i_req  = req_q;
    assign i_data = data_q;
    assign i_id   = id_q;

endmodule

// File: tb/tb_eb_rr_arbiter.sv
// tb/tb_eb_rr_arbiter.sv - directed bench with behavioural model for eb_rr_arbiter
module tb_eb_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] t_req;
    logic [N-1:0] t_ack;
    logic [N*W-1:0] t_data;
    logic [N-1:0] t_last;
    logic         i_req;
    logic         i_ack;
    logic [W-1:0] i_data;
    logic [1:0]   i_id;

    always #5 clk = ~clk;

    eb_rr_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .t_req(t_req), .t_ack(t_ack), .t_data(t_data), .t_last(t_last),
        .i_req(i_req), .i_ack(i_ack), .i_data(i_data), .i_id(i_id)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: output slot, priority pointer and lock state as plain integers.
    int         m_prio;
    int         m_lk;
    bit         m_locked;
    bit         m_req;
    logic [7:0] m_data;
    int         m_id;
    int         id_log[$];
    logic [3:0] m_g;
    int         m_k;

    function automatic logic [3:0] exp_grant();
        if (!reset_n) return 4'b0;
        if (m_req && !i_ack) return 4'b0;
`ifdef EB_ARB_LOCK_EN
        if (m_locked) return t_req[m_lk] ? 4'(1 << m_lk) : 4'b0;
`endif
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_prio + i) % N;
            if (t_req[c]) return 4'(1 << c);
        end
        return 4'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prio = 0; m_lk = 0; m_locked = 0; m_req = 0; m_data = 8'h00; m_id = 0;
        end else begin
            m_g = exp_grant();
            if (m_g != 4'b0) begin
                m_k = 0;
                for (int i = 0; i < N; i++) if (m_g[i]) m_k = i;
                m_data = t_data[m_k*W +: W];
                m_id   = m_k;
                m_req  = 1;
                m_prio = (m_k + 1) % N;
                id_log.push_back(m_k);
                if (!m_locked && !t_last[m_k]) begin
                    m_locked = 1;
                    m_lk     = m_k;
                end else if (m_locked && t_last[m_k]) begin
                    m_locked = 0;
                end
            end else if (i_ack) begin
                m_req = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("t_ack", {28'b0, t_ack}, {28'b0, exp_grant()});
        chk("i_req", {31'b0, i_req}, {31'b0, m_req});
        chk("i_data", {24'b0, i_data}, {24'b0, m_data});
        chk("i_id", {30'b0, i_id}, m_id[31:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_len"}, id_log.size(), 4);
        for (int i = 0; i < 4 && i < id_log.size(); i++) chk(nm, id_log[i], e[i]);
    endtask

    initial begin
        int rem2;
        logic [3:0] a;
        reset_n = 1'b0;
        t_req   = 4'hF;
        i_ack   = 1'b1;
        t_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        t_last  = 4'hF;

        // Reset with all requests asserted
        step();
        @(negedge clk);
        chk("rst_ack", {28'b0, t_ack}, 32'h0);
        chk("rst_req", {31'b0, i_req}, 32'h0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_ack", {28'b0, t_ack}, 32'h1);

        // Full contention
        for (int i = 0; i < 6; i++) begin
            step();
            chk("cont_req", {31'b0, i_req}, 32'h1);
        end
        chk("cont_len", id_log.size(), 6);
        if (id_log.size() == 6) begin
            chk("cont_id0", id_log[0], 0); chk("cont_id1", id_log[1], 1);
            chk("cont_id2", id_log[2], 2); chk("cont_id3", id_log[3], 3);
            chk("cont_id4", id_log[4], 0); chk("cont_id5", id_log[5], 1);
        end
        t_req = 4'b0;
        step();
        chk("drain_req", {31'b0, i_req}, 32'h0);

        // Backpressure
        t_req = 4'b0001;
        t_data[7:0] = 8'hA5;
        step();
        t_req = 4'b0010;
        t_data[15:8] = 8'h5A;
        i_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", {24'b0, i_data}, 32'hA5);
            chk("bp_id", {30'b0, i_id}, 32'h0);
            chk("bp_ack", {28'b0, t_ack}, 32'h0);
            step();
        end
        i_ack = 1'b1;
        @(negedge clk);
        chk("bp_reload_ack", {28'b0, t_ack}, 32'h2);
        step();
        chk("bp_new_data", {24'b0, i_data}, 32'h5A);
        chk("bp_new_id", {30'b0, i_id}, 32'h1);
        t_req = 4'b0;
        step();

        // Mid-operation reset discards the held beat
        t_req = 4'b0100;
        t_data[23:16] = 8'h77;
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, i_req}, 32'h0);
        chk("mid_rst_data", {24'b0, i_data}, 32'h0);
        t_req = 4'b0;
        step();
        reset_n = 1'b1;

        // Wrap and drain
        id_log.delete();
        t_req = 4'b1000;
        t_data[31:24] = 8'hD3;
        step();
        chk("wrap_prio_a", m_prio, 0);
        t_req = 4'b0001;
        t_data[7:0] = 8'h0D;
        step();
        chk("wrap_prio_b", m_prio, 1);
        t_req = 4'b0;
        step();
        chk("wrap_drain_req", {31'b0, i_req}, 32'h0);
        chk("wrap_len", id_log.size(), 2);
        if (id_log.size() == 2) begin
            chk("wrap_id0", id_log[0], 3);
            chk("wrap_id1", id_log[1], 0);
        end
        i_ack = 1'b0;
        step();
        step();
        i_ack = 1'b1;
        step();
        chk("idle_req", {31'b0, i_req}, 32'h0);
        chk("idle_data", {24'b0, i_data}, 32'h0D);
        chk("idle_id", {30'b0, i_id}, 32'h0);
        chk("idle_prio", m_prio, 1);

        // Packet lock scenario
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        id_log.delete();
        rem2 = 3;
        for (int c = 0; c < 20 && id_log.size() < 4; c++) begin
            t_req  = {1'b0, rem2 > 0, 1'b0, c >= 1};
            t_last = {1'b0, rem2 == 1, 2'b00};
            t_data[23:16] = 8'hC0 + 8'(3 - rem2);
            t_data[7:0]   = 8'h0A;
            @(negedge clk);
            a = t_ack;
            step();
            if (a[2]) rem2--;
        end
`ifdef EB_ARB_LOCK_EN
        chk_log("lock_id", 2, 2, 2, 0);
`else
        chk_log("lock_id", 2, 0, 2, 0);
`endif
        t_req = 4'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
